sync_fifo_stream_reader: RTL and testbench

Read-side engine for the team's synchronous FIFO (`clk`/`rst`, `wr_en`/`rd_en`, `data`/`dout`, `full`/`empty`). It drives the FIFO's `rd_en` and absorbs the FIFO's one-cycle read latency in a 2-entry output buffer. Popped words are presented on a valid/ready stream with a packet `last` marker every `PKT_LEN` words. It sits between the FIFO and any downstream consumer, and sustains one word per cycle when the FIFO is non-empty and the consumer is ready.

---
 rtl/sync_fifo_stream_reader.sv | 113 +++++++++++
 tb/tb_sync_fifo_stream_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_stream_reader.sv
// Read-side engine for the synchronous FIFO. It issues FIFO reads, absorbs the
// one-cycle read latency in a 2-entry skid buffer and presents the words on a
// valid/ready stream with a packet-end marker every PKT_LEN transferred words.
module sync_fifo_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] xfer_count,
  output logic             busy
);

  // A packet counter needs at least one bit even when every word ends a packet.
  localparam int              PC_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PC_W-1:0] PKT_LAST = PC_W'(PKT_LEN - 1);

  logic [1:0]       occ_q, occ_d;            // buffer occupancy, 0..2
  logic             inflight_q, inflight_d;  // read accepted last cycle
  logic [WIDTH-1:0] buf0_q, buf0_d;          // head entry, drives m_data
  logic [WIDTH-1:0] buf1_q, buf1_d;          // second entry
  logic [PC_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;

  logic       out_fire;
  logic       capture;
  logic [2:0] pending;

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf0_q;
  assign m_last     = m_valid && (pkt_cnt_q == PKT_LAST);
  assign xfer_count = xfer_count_q;
  assign busy       = inflight_q || m_valid;

  assign out_fire = m_valid && m_ready;
  assign capture  = inflight_q;
  assign pending  = {1'b0, occ_q} + {2'b00, inflight_q};

  // Issue a read only when the word is guaranteed a buffer slot on arrival;
  // the pop this cycle frees a slot, hence the combinational m_ready path.
  always_comb begin
    fifo_rd_en = !rst && enable && !fifo_empty &&
                 (pending < (3'd2 + {2'b00, out_fire}));
  end

  // Next-state for the skid buffer, read tracking and transfer counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    occ_d        = occ_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    inflight_d   = fifo_rd_en;
    pkt_cnt_d    = pkt_cnt_q;
    xfer_count_d = xfer_count_q;

    if (capture && out_fire) begin
      // Pop and capture together: occupancy unchanged, entries shift forward.
      if (occ_q == 2'd2) begin
        buf0_d = buf1_q;
        buf1_d = fifo_dout;
      end else begin
        buf0_d = fifo_dout;
      end
    end else if (capture) begin
      // Read-issue gating guarantees occupancy is below 2 here.
      if (occ_q == 2'd0) buf0_d = fifo_dout;
      else               buf1_d = fifo_dout;
      occ_d = occ_q + 2'd1;
    end else if (out_fire) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end

    if (out_fire) begin
      pkt_cnt_d    = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + PC_W'(1);
      xfer_count_d = xfer_count_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from the same
    // pre-edge values, independent of statement order.
    if (rst) begin
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      // NOTE: the buffer entries are reset too, because m_data is read straight
      // from the head entry and must be 0 out of reset.
      buf0_q       <= '0;
      buf1_q       <= '0;
      pkt_cnt_q    <= '0;
      xfer_count_q <= '0;
    end else begin
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      pkt_cnt_q    <= pkt_cnt_d;
      xfer_count_q <= xfer_count_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Scoreboard bench for sync_fifo_stream_reader. A behavioural FIFO with
// one-cycle read latency feeds the DUT; words written to it are queued as
// expected output, and a negedge monitor compares every transferred word and
// the stream/handshake flags derived from word counts.
module tb_sync_fifo_stream_reader;

  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 16;
  localparam int DEPTH   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [CNT_W-1:0] xfer_count;
  logic             busy;

  // Stimulus-side FIFO write port and modes.
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  bit               stall_mode = 1'b0;
  bit               run_mon = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference state: FIFO contents, expected stream, word counts since reset.
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] expq[$];
  int  acc_cnt = 0;   // FIFO reads accepted
  int  cap_cnt = 0;   // accepted reads whose data has reached the reader
  int  out_cnt = 0;   // words transferred on the output
  bit  rd_prev = 1'b0;

  sync_fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .xfer_count (xfer_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((fq.size() != 0 || expq.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still expected after %0d cycles", expq.size(), budget);
    end
  endtask

  // Behavioural synchronous FIFO plus word-count bookkeeping.
  always @(posedge clk) begin
    bit acc_now;
    bit stall_now;
    if (rst) begin
      fq.delete();
      expq.delete();
      acc_cnt = 0;
      cap_cnt = 0;
      out_cnt = 0;
      rd_prev = 1'b0;
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      acc_now = fifo_rd_en && !fifo_empty;
      if (rd_prev) cap_cnt++;
      if (m_valid && m_ready) out_cnt++;
      if (acc_now && fq.size() > 0) begin
        fifo_dout <= fq.pop_front();
        acc_cnt++;
      end
      rd_prev = acc_now;
      if (wr_en && fq.size() < DEPTH) begin
        fq.push_back(wr_data);
        expq.push_back(wr_data);
      end
      stall_now  = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
      fifo_empty <= (fq.size() == 0) || stall_now;
    end
  end

  // Monitor: compares outputs against counts and the expected-word queue.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;
  always @(negedge clk) begin
    int  occ_m;
    int  pend;
    bit  exp_valid;
    bit  exp_rd;
    logic [WIDTH-1:0] e;
    if (rst || !run_mon) begin
      prev_stall = 1'b0;
    end else begin
      occ_m     = cap_cnt - out_cnt;
      pend      = acc_cnt - out_cnt;
      exp_valid = (occ_m > 0);
      exp_rd    = enable && !fifo_empty && ((pend - ((exp_valid && m_ready) ? 1 : 0)) < 2);
      check("m_valid", m_valid, exp_valid);
      check("busy", busy, pend > 0);
      check("fifo_rd_en", fifo_rd_en, exp_rd);
      check("xfer_count", xfer_count, out_cnt[CNT_W-1:0]);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          e = expq.pop_front();
          check("m_data", m_data, e);
          check("m_last", m_last, (out_cnt % PKT_LEN) == PKT_LEN - 1);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_last", m_last, 1'b0);
    check("rst_xfer_count", xfer_count, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    rst = 1'b0;
    run_mon = 1'b1;

    // Streaming 0..7 with fixed latency and one word per cycle.
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    enable = 1'b1;
    #1;
    check("lat_rd_en_n", fifo_rd_en, 1'b1);
    tick();
    check("lat_valid_n1", m_valid, 1'b0);
    tick();
    check("lat_valid_n2", m_valid, 1'b1);
    check("lat_data_n2", m_data, 8'h00);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("stream_valid", m_valid, 1'b1);
      check("stream_data", m_data, 8'(i));
    end
    tick();
    check("stream_done_valid", m_valid, 1'b0);
    check("stream_done_busy", busy, 1'b0);
    check("stream_done_count", xfer_count, 16'd8);

    // Backpressure with m_ready pattern 1,0,0,1.
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(10 + i));
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    m_ready = 1'b1;
    wait_drain(100);
    check("bp_count", xfer_count, 16'd16);

    // Empty FIFO with the reader enabled, then a short packet.
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_rd_en", fifo_rd_en, 1'b0);
      check("idle_valid", m_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
    for (int i = 0; i < 4; i++) push_word(8'(100 + i));
    wait_drain(100);
    check("short_count", xfer_count, 16'd20);

    // Enable dropped after three accepted reads, then resumed.
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(40 + i));
    enable = 1'b1;
    tick();
    tick();
    tick();
    enable = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("pause_valid", m_valid, 1'b0);
    check("pause_busy", busy, 1'b0);
    check("pause_count", xfer_count, 16'd23);
    enable = 1'b1;
    wait_drain(100);
    check("resume_count", xfer_count, 16'd28);

    // Reset after two words of a packet.
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(60 + i));
    enable = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("pre_rst_count", xfer_count, 16'd30);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", m_valid, 1'b0);
    check("mid_rst_data", m_data, 8'h00);
    check("mid_rst_last", m_last, 1'b0);
    check("mid_rst_count", xfer_count, 16'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rd_en", fifo_rd_en, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(70 + i));
    wait_drain(100);
    check("post_rst_count", xfer_count, 16'd8);

    // Concurrent write and read at one word per cycle.
    for (int i = 0; i < 20; i++) begin
      if (i >= 3) check("conc_valid", m_valid, 1'b1);
      check("conc_not_full", fq.size() < DEPTH, 1'b1);
      wr_en   = 1'b1;
      wr_data = 8'(80 + i);
      tick();
    end
    wr_en = 1'b0;
    wait_drain(100);
    check("conc_count", xfer_count, 16'd28);

    // Random data with a flickering empty flag and random backpressure.
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'($urandom_range(0, 255)));
    stall_mode = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      m_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    m_ready = 1'b1;
    wait_drain(200);
    stall_mode = 1'b0;
    check("rand_count", xfer_count, 16'd36);

    tick();
    run_mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
